apb_cmd_master: RTL and testbench
=================================

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- ADDR_WIDTH, 8, PADDR/cmd_addr width
- DATA_WIDTH, 32, data width, multiple of 8
- TIMEOUT, 16, maximum ACCESS wait cycles; 0 disables the timeout
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- PCLK  in  1  clock, rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  slave error or timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH; PSTRB  out  DATA_WIDTH/8
- PRDATA  in  DATA_WIDTH; PREADY  in  1; PSLVERR  in  1
REQ-003 The block SHALL use one clock, PCLK, and an asynchronous active-low reset, PRESETn.

Function
REQ-004 The FSM SHALL have four states: IDLE, SETUP, ACCESS and RESP.
REQ-005 cmd_ready SHALL be high only in IDLE with PRESETn high. A command SHALL be accepted on an edge where cmd_valid and cmd_ready are both high.
REQ-006 On acceptance, the block SHALL register cmd_write, cmd_addr, cmd_wdata and cmd_strb into PWRITE, PADDR, PWDATA and PSTRB, with PSTRB forced to 0 for reads. The FSM SHALL then go to SETUP.
REQ-007 In SETUP, PSEL SHALL be 1 and PENABLE 0 for exactly one cycle. The FSM SHALL then go to ACCESS.
REQ-008 In ACCESS, PSEL and PENABLE SHALL both be 1. PADDR, PWRITE, PWDATA and PSTRB SHALL stay stable from SETUP until ACCESS completes.
REQ-009 ACCESS SHALL complete on the first edge with PREADY=1:
- rsp_err <= PSLVERR
- rsp_rdata <= PRDATA when the transfer is a read, PREADY=1 and PSLVERR=0; otherwise 0
- PSEL and PENABLE <= 0
- FSM goes to RESP
REQ-010 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS edge with PREADY=0.
REQ-011 If TIMEOUT>0 and the wait counter reaches TIMEOUT, ACCESS SHALL end: rsp_err=1, rsp_rdata=0, PSEL/PENABLE=0, FSM goes to RESP.
REQ-012 The wait counter SHALL be clog2(TIMEOUT+1) bits wide and SHALL NOT wrap.
REQ-013 In RESP, rsp_valid SHALL be 1, with rsp_rdata and rsp_err held stable until rsp_ready=1. On that edge, rsp_valid SHALL clear and the FSM SHALL go to IDLE.
REQ-014 PSEL SHALL be 0 in IDLE and RESP. PADDR, PWRITE, PWDATA and PSTRB SHALL hold their last values when PSEL=0.
REQ-015 Minimum latency SHALL be acceptance edge N, SETUP in cycle N+1, ACCESS in cycle N+2, rsp_valid in cycle N+3 (zero-wait slave). Minimum command spacing SHALL be 4 cycles.
REQ-016 A PREADY=1 on the same edge where the wait counter reaches TIMEOUT SHALL be treated as normal completion, not timeout.
REQ-017 cmd_valid SHALL be ignored outside IDLE. PREADY, PSLVERR and PRDATA SHALL be ignored outside ACCESS.

Reset
REQ-018 While PRESETn=0, regardless of clock, the block SHALL force the FSM to IDLE, wait counter to 0, and all outputs to 0, including cmd_ready.
REQ-019 A reset during SETUP, ACCESS or RESP SHALL abort the transfer with no response. The first command SHALL be accepted on the first edge after PRESETn rises.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Write addr 0x10, data 0xDEADBEEF, strb 0xF, PREADY tied 1 -> one SETUP and one ACCESS cycle with PADDR=0x10, PWDATA=0xDEADBEEF, PSTRB=0xF; rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
- Read addr 0x04, PREADY low 3 ACCESS cycles then high with PRDATA=0x12345678 -> PADDR stable for 4 ACCESS cycles; rsp_rdata=0x12345678, rsp_err=0.
- Read addr 0xFF, PSLVERR=1 with PREADY=1 -> rsp_err=1, rsp_rdata=0; PSTRB=0 throughout.
- PREADY held 0, TIMEOUT=16 -> 16 ACCESS wait cycles, then rsp_err=1, PSEL=0; PREADY=1 on the 16th edge -> normal completion.
- rsp_ready held 0 for 5 cycles -> rsp_valid and rsp data stable, cmd_ready=0, a second cmd_valid is not accepted until 1 cycle after rsp_ready.
- PRESETn pulsed low mid-ACCESS -> PSEL, PENABLE, rsp_valid and cmd_ready go 0 immediately; after release, IDLE and a new command is accepted.

Source files
------------

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - command/response to APB master bridge
//
// Purpose: accepts one command at a time on a valid/ready command port,
// runs it as a single APB transfer (SETUP then ACCESS), and returns the
// result on a valid/ready response port. An optional ACCESS wait limit
// converts an unresponsive slave into an error response.
//
// Ports:
//   PCLK, PRESETn            clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_write, cmd_addr,     command fields
//   cmd_wdata, cmd_strb
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata, rsp_err       response fields (rdata is 0 for writes/errors)
//   PSEL, PENABLE, PWRITE,   APB master outputs
//   PADDR, PWDATA, PSTRB
//   PRDATA, PREADY, PSLVERR  APB slave returns
module apb_cmd_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int SW = DATA_WIDTH / 8;
    // A disabled timeout still needs a legal (1-bit) counter.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           wait_q;
    logic [CW-1:0]           wait_d;
    logic                    psel_q;
    logic                    penable_q;
    logic                    pwrite_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [SW-1:0]           pstrb_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    timeout_hit;

    // Saturating increment so the counter can never wrap back to zero.
    assign wait_d      = (wait_q == {CW{1'b1}}) ? wait_q : wait_q + CW'(1);
    assign timeout_hit = (TIMEOUT != 0) && (wait_d == TO_CNT);

    // Combinational so the first command can be taken on the very first
    // edge after reset release; the reset term keeps it low during reset.
    assign cmd_ready = PRESETn && (state_q == IDLE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite_q <= cmd_write;
                        paddr_q  <= cmd_addr;
                        pwdata_q <= cmd_wdata;
                        pstrb_q  <= cmd_write ? cmd_strb : '0;
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    wait_q    <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY wins over a timeout landing on the same edge.
                    if (PREADY) begin
                        rsp_err_q   <= PSLVERR;
                        rsp_rdata_q <= (!pwrite_q && !PSLVERR) ? PRDATA : '0;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= RESP;
                    end else if (timeout_hit) begin
                        wait_q      <= wait_d;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= RESP;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - self-checking bench for apb_cmd_master
module tb_apb_cmd_master;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [3:0]    PSTRB;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    apb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    strb;
        int            nwait;     // ACCESS cycles with PREADY=0 before PREADY=1
        logic [DW-1:0] prdata;
        logic          slverr;
        int            hold;      // cycles rsp_ready stays low in RESP
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic [3:0]    exp_pstrb;
    } vec_t;

    vec_t vecs [8];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Drives one command through SETUP/ACCESS and checks up to rsp_valid.
    task automatic issue_and_access(input vec_t v);
        bit to;
        int n;
        chk("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_strb  = v.strb;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;
        cmd_strb  = ~v.strb;
        cmd_write = ~v.write;
        to = (v.nwait >= TO);
        n  = to ? TO : v.nwait + 1;
        chk("setup_psel", PSEL, 1);
        chk("setup_penable", PENABLE, 0);
        chk("setup_paddr", PADDR, v.addr);
        chk("setup_pwrite", PWRITE, v.write);
        chk("setup_pwdata", PWDATA, v.wdata);
        chk("setup_pstrb", PSTRB, v.exp_pstrb);
        chk("setup_cmd_ready", cmd_ready, 0);
        // Same level as the first ACCESS cycle: must be ignored in SETUP.
        PREADY = (!to && v.nwait == 0);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("access_psel", PSEL, 1);
            chk("access_penable", PENABLE, 1);
            chk("access_paddr", PADDR, v.addr);
            chk("access_pwdata", PWDATA, v.wdata);
            chk("access_pstrb", PSTRB, v.exp_pstrb);
            chk("access_rsp_valid", rsp_valid, 0);
            PREADY  = (!to && i == v.nwait);
            PSLVERR = PREADY ? v.slverr : 1'b0;
            PRDATA  = PREADY ? v.prdata : (32'hBAD0_0000 | i);
        end
        tick();
        // Garbage on the slave side while in RESP must not disturb the response.
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        PRDATA  = 32'h5A5A_5A5A;
        chk("resp_valid", rsp_valid, 1);
        chk("resp_psel", PSEL, 0);
        chk("resp_penable", PENABLE, 0);
        chk("resp_rdata", rsp_rdata, v.exp_rdata);
        chk("resp_err", rsp_err, v.exp_err);
        chk("resp_cmd_ready", cmd_ready, 0);
    endtask

    task automatic finish_rsp(input vec_t v);
        for (int h = 0; h < v.hold; h++) begin
            tick();
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, v.exp_rdata);
            chk("hold_err", rsp_err, v.exp_err);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_psel", PSEL, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        chk("done_rsp_valid", rsp_valid, 0);
        chk("done_cmd_ready", cmd_ready, 1);
        chk("done_psel", PSEL, 0);
        chk("done_paddr_held", PADDR, v.addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            wr    addr   wdata         strb  nw  prdata        err  hold exp_rdata     exp_err pstrb
        vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0,  32'hAAAA5555, 1'b0, 0, 32'h0,        1'b0, 4'hF};
        vecs[1] = '{1'b0, 8'h04, 32'h0,        4'hF, 3,  32'h12345678, 1'b0, 0, 32'h12345678, 1'b0, 4'h0};
        vecs[2] = '{1'b0, 8'hFF, 32'h0,        4'hF, 0,  32'hCAFEF00D, 1'b1, 1, 32'h0,        1'b1, 4'h0};
        vecs[3] = '{1'b0, 8'h20, 32'h0,        4'h0, 16, 32'h0,        1'b0, 0, 32'h0,        1'b1, 4'h0};
        vecs[4] = '{1'b0, 8'h21, 32'h0,        4'h0, 15, 32'h0BADCAFE, 1'b0, 0, 32'h0BADCAFE, 1'b0, 4'h0};
        vecs[5] = '{1'b1, 8'h30, 32'h11223344, 4'h5, 2,  32'h77777777, 1'b1, 5, 32'h0,        1'b1, 4'h5};
        vecs[6] = '{1'b1, 8'h40, 32'hA5A5A5A5, 4'hA, 1,  32'h66666666, 1'b0, 2, 32'h0,        1'b0, 4'hA};
        vecs[7] = '{1'b0, 8'h66, 32'h0,        4'h3, 0,  32'h87654321, 1'b0, 0, 32'h87654321, 1'b0, 4'h0};

        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        #2;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        cmd_valid = 1'b1;
        repeat (2) tick();
        chk("rst_psel_clocked", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp_err", rsp_err, 0);
        cmd_valid = 1'b0;
        PRESETn   = 1'b1;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        for (int k = 0; k < 7; k++) begin
            issue_and_access(vecs[k]);
            finish_rsp(vecs[k]);
        end

        // Command offered throughout a stalled response is taken only once
        // the FSM is back in IDLE.
        issue_and_access(vecs[0]);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h55;
        cmd_wdata = 32'h5555AAAA;
        cmd_strb  = 4'h3;
        for (int h = 0; h < 5; h++) begin
            tick();
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_cmd_ready", cmd_ready, 0);
            chk("stall_psel", PSEL, 0);
            chk("stall_paddr", PADDR, 8'h10);
            chk("stall_rdata", rsp_rdata, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        chk("stall_rel_rsp_valid", rsp_valid, 0);
        chk("stall_rel_cmd_ready", cmd_ready, 1);
        chk("stall_rel_psel", PSEL, 0);
        tick();
        cmd_valid = 1'b0;
        chk("second_psel", PSEL, 1);
        chk("second_penable", PENABLE, 0);
        chk("second_paddr", PADDR, 8'h55);
        chk("second_pwdata", PWDATA, 32'h5555AAAA);
        chk("second_pstrb", PSTRB, 4'h3);
        tick();
        chk("second_access", PENABLE, 1);
        PREADY = 1'b1;
        tick();
        PREADY = 1'b0;
        chk("second_rsp_valid", rsp_valid, 1);
        chk("second_rsp_err", rsp_err, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("second_done_ready", cmd_ready, 1);

        // Reset mid-ACCESS aborts the transfer without a response.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h77;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("pre_rst_penable", PENABLE, 1);
        tick();
        #3;
        PRESETn = 1'b0;
        #1;
        chk("midrst_psel", PSEL, 0);
        chk("midrst_penable", PENABLE, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        chk("midrst_paddr", PADDR, 0);
        #1;
        PRESETn = 1'b1;
        #1;
        chk("rel_cmd_ready", cmd_ready, 1);
        issue_and_access(vecs[7]);
        finish_rsp(vecs[7]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
